// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM state encoding and tap counter width for adc_lane_align
package adc_pkg;
    localparam int TAPW = 8;
    typedef enum logic [3:0] {
        S_IDLE, S_DRESET, S_CAL, S_WAITCAL, S_CHECK,
        S_SLIP, S_INCDLY, S_SETTLE, S_NEXT, S_DONE
    } state_t;
endpackage

// File: rtl/adc_lane_align_if.sv
// adc_lane_align_if: ADC lane alignment bus between the fabric and the aligner
// ADC_ALIGN_TAPOUT_EN adds the per-lane final tap readout.
interface adc_lane_align_if
    import adc_pkg::*;
#(
    parameter int NLANES = 8,
    parameter int WIDTH = 6
);
    logic start;
    logic [NLANES*WIDTH-1:0] data;
    logic [NLANES-1:0] busy;
    logic [NLANES-1:0] bs;
    logic [NLANES-1:0] dinc;
    logic drst;
    logic dcal;
    logic srst;
    logic [NLANES-1:0] lock;
    logic [NLANES-1:0] err;
    logic done;
`ifdef ADC_ALIGN_TAPOUT_EN
    logic [NLANES*TAPW-1:0] tap;
    modport master (output start, data, busy, input bs, dinc, drst, dcal, srst, lock, err, done, tap);
    modport slave (input start, data, busy, output bs, dinc, drst, dcal, srst, lock, err, done, tap);
`else
    modport master (output start, data, busy, input bs, dinc, drst, dcal, srst, lock, err, done);
    modport slave (input start, data, busy, output bs, dinc, drst, dcal, srst, lock, err, done);
`endif
endinterface

// File: rtl/adc_match_cnt.sv
// adc_match_cnt: consecutive-match counter; term fires on the NCHECK-th match in a row
module adc_match_cnt #(
    parameter int NCHECK = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic match,
    output logic term
);
    localparam int CW = $clog2(NCHECK + 1);
    logic [CW-1:0] cnt;
    assign term = !clr && match && cnt == CW'(NCHECK - 1);
    always_ff @(posedge clk) begin
        cnt <= (rst || clr || !match || term) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/adc_lane_align.sv
// adc_lane_align: per-lane bitslip/IODELAY training-word alignment sequencer
// Define ADC_ALIGN_TAPOUT_EN to expose the final tap count of each lane.
module adc_lane_align
    import adc_pkg::*;
#(
    parameter int NLANES = 8,
    parameter int WIDTH = 6,
    parameter logic [WIDTH-1:0] PATTERN = 6'b111000,
    parameter int SETTLE = 4,
    parameter int NCHECK = 16,
    parameter int MAXTAP = 63
) (
    input logic clk,
    input logic rst,
    adc_lane_align_if.slave bus
);
    localparam int LW = NLANES > 1 ? $clog2(NLANES) : 1;
    localparam int SW = $clog2(WIDTH);
    localparam int WW = $clog2(SETTLE + 1);
    state_t state, state_n;
    logic [LW-1:0] lane;
    logic [SW-1:0] slip;
    logic [TAPW-1:0] tap;
    logic [WW-1:0] wcnt;
    logic [NLANES-1:0] lock, err;
    logic [WIDTH-1:0] word;
    logic match, term, go, last_slip, last_tap, last_lane;
    assign word = bus.data[lane*WIDTH +: WIDTH];
    assign match = word == PATTERN;
    assign go = (state == S_IDLE || state == S_DONE) && bus.start;
    assign last_slip = slip == SW'(WIDTH - 1);
    assign last_tap = tap == TAPW'(MAXTAP);
    assign last_lane = lane == LW'(NLANES - 1);
    adc_match_cnt #(.NCHECK(NCHECK)) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .clr(state != S_CHECK),
        .match(match),
        .term(term)
    );
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: state_n = go ? S_DRESET : state;
            S_DRESET:       state_n = S_CAL;
            S_CAL:          state_n = S_WAITCAL;
            S_WAITCAL:      state_n = (wcnt != '0 && bus.busy == '0) ? S_CHECK : S_WAITCAL;
            S_CHECK:        state_n = term ? S_NEXT : match ? S_CHECK : !last_slip ? S_SLIP : !last_tap ? S_INCDLY : S_NEXT;
            S_SLIP, S_INCDLY: state_n = S_SETTLE;
            S_SETTLE:       state_n = wcnt == WW'(SETTLE - 1) ? S_CHECK : S_SETTLE;
            S_NEXT:         state_n = last_lane ? S_DONE : S_CHECK;
            default:        state_n = S_IDLE;
        endcase
    end
    // wcnt doubles as the WAITCAL minimum-dwell flag and the SETTLE timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            lane <= '0;
            slip <= '0;
            tap <= '0;
            wcnt <= '0;
            lock <= '0;
            err <= '0;
        end else begin
            state <= state_n;
            wcnt <= state == S_SETTLE ? wcnt + WW'(1) : state == S_WAITCAL ? WW'(1) : '0;
            slip <= state == S_SLIP ? slip + SW'(1) : state inside {S_INCDLY, S_WAITCAL, S_NEXT} ? '0 : slip;
            tap <= state == S_INCDLY ? tap + TAPW'(1) : state inside {S_WAITCAL, S_NEXT} ? '0 : tap;
            lane <= go ? '0 : (state == S_NEXT && !last_lane) ? lane + LW'(1) : lane;
            lock <= go ? '0 : (state == S_CHECK && term) ? lock | (NLANES'(1) << lane) : lock;
            err <= go ? '0 : (state == S_CHECK && !match && last_slip && last_tap) ? err | (NLANES'(1) << lane) : err;
        end
    end
    assign bus.drst = state == S_DRESET;
    assign bus.srst = state == S_DRESET;
    assign bus.dcal = state == S_CAL;
    assign bus.done = state == S_DONE;
    assign bus.bs = state == S_SLIP ? NLANES'(1) << lane : '0;
    assign bus.dinc = state == S_INCDLY ? NLANES'(1) << lane : '0;
    assign bus.lock = lock;
    assign bus.err = err;
`ifdef ADC_ALIGN_TAPOUT_EN
    logic [NLANES*TAPW-1:0] tap_q;
    always_ff @(posedge clk) begin
        if (rst || go) tap_q <= '0;
        else if (state == S_NEXT) tap_q[lane*TAPW +: TAPW] <= tap;
    end
    assign bus.tap = tap_q;
`endif
endmodule

// File: tb/tb_adc_lane_align.sv
// tb_adc_lane_align: directed checks of adc_lane_align against a bitslip/IODELAY lane model
module tb_adc_lane_align;
    localparam int NL = 8;
    localparam int W = 6;
    localparam logic [5:0] P = 6'b111000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    int kind [NL];
    int off [NL];
    int sp [NL];
    int tp [NL];
    int nbs [NL];
    int ndinc [NL];
    int bs_first [NL];
    int bs_total, dinc_total, ndrst, viol;
    logic [NL-1:0] pbs = '0;
    logic [NL-1:0] pdinc = '0;
    adc_lane_align_if #(.NLANES(NL), .WIDTH(W)) bus ();
    adc_lane_align #(.NLANES(NL), .WIDTH(W), .PATTERN(P)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic logic [5:0] rotr(input logic [5:0] w, input int n);
        logic [11:0] d;
        d = {w, w};
        return d[n +: 6];
    endfunction
    // lane model: kind 0 = pattern rotated by off+slips, 1 = pattern only at tap off, 2 = stuck at zero
    always @(negedge clk) begin
        if (bus.drst) begin
            ndrst++;
            bs_total = 0;
            dinc_total = 0;
            viol = 0;
        end
        for (int i = 0; i < NL; i++) begin
            if (bus.drst) begin
                nbs[i] = 0;
                ndinc[i] = 0;
                bs_first[i] = -1;
            end
            if (bus.srst) begin
                sp[i] = 0;
                tp[i] = 0;
            end
            if (bus.bs[i]) begin
                sp[i] = (sp[i] + 1) % W;
                nbs[i]++;
                bs_total++;
            end
            if (bus.dinc[i]) begin
                tp[i]++;
                ndinc[i]++;
                dinc_total++;
                if (ndinc[i] == 1) bs_first[i] = nbs[i];
            end
            bus.data[i*W +: W] = kind[i] == 0 ? rotr(P, (off[i] + sp[i]) % W) :
                                 (kind[i] == 1 && tp[i] == off[i]) ? P : 6'h00;
        end
        if (!$onehot0(bus.bs | bus.dinc) || |(bus.bs & pbs) || |(bus.dinc & pdinc)) viol++;
        pbs = bus.bs;
        pdinc = bus.dinc;
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic run(output int cyc);
        bus.start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
        end while (!bus.done && cyc < 6000);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_lock"}, bus.lock, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pulses"}, {bus.bs, bus.dinc, bus.drst, bus.dcal, bus.srst}, 0);
    endtask
    initial begin
        int cyc, d, d0, b0;
        bus.start = 1'b0;
        bus.busy = '0;
        for (int i = 0; i < NL; i++) begin
            kind[i] = 0;
            off[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        // all lanes already aligned
        d0 = ndrst;
        run(cyc);
        check("t1_done", bus.done, 1);
        check("t1_cycles", cyc, 141);
        check("t1_lock", bus.lock, 8'hFF);
        check("t1_err", bus.err, 0);
        check("t1_bs", bs_total, 0);
        check("t1_dinc", dinc_total, 0);
        check("t1_drst", ndrst - d0, 1);
        check("t1_viol", viol, 0);
        // lane 3 rotated by two bits
        off[3] = 4;
        run(cyc);
        check("t2_done", bus.done, 1);
        check("t2_bs3", nbs[3], 2);
        check("t2_bs_total", bs_total, 2);
        check("t2_dinc", dinc_total, 0);
        check("t2_lock", bus.lock, 8'hFF);
        check("t2_err", bus.err, 0);
        off[3] = 0;
        // lane 5 only valid at tap 2
        kind[5] = 1;
        off[5] = 2;
        run(cyc);
        check("t3_done", bus.done, 1);
        check("t3_dinc5", ndinc[5], 2);
        check("t3_bs_before_dinc", bs_first[5], 5);
        check("t3_bs5", nbs[5], 10);
        check("t3_lock", bus.lock, 8'hFF);
        check("t3_viol", viol, 0);
`ifdef ADC_ALIGN_TAPOUT_EN
        check("t3_tap5", bus.tap[47:40], 2);
`endif
        kind[5] = 0;
        off[5] = 0;
        // lane 0 stuck at zero exhausts every tap
        kind[0] = 2;
        run(cyc);
        check("t4_done", bus.done, 1);
        check("t4_dinc0", ndinc[0], 63);
        check("t4_bs0", nbs[0], 320);
        check("t4_err", bus.err, 8'h01);
        check("t4_lock", bus.lock, 8'hFE);
        check("t4_viol", viol, 0);
`ifdef ADC_ALIGN_TAPOUT_EN
        check("t4_tap0", bus.tap[7:0], 63);
`endif
        kind[0] = 0;
        // BUSY held after DCAL delays CHECK
        off[0] = 1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        d = 0;
        while (!bus.dcal && d < 20) begin
            @(negedge clk);
            d++;
        end
        check("t5_dcal", bus.dcal, 1);
        bus.busy = '1;
        repeat (20) @(negedge clk);
        b0 = nbs[0];
        bus.busy = '0;
        d = 0;
        do begin
            @(negedge clk);
            d++;
        end while (!bus.bs[0] && d < 50);
        check("t5_no_slip_while_busy", b0, 0);
        check("t5_check_delay", d, 2);
        while (!bus.done && d < 5000) begin
            @(negedge clk);
            d++;
        end
        check("t5_done", bus.done, 1);
        check("t5_lock", bus.lock, 8'hFF);
        check("t5_bs0", nbs[0], 5);
        off[0] = 0;
        // reset during a lane 2 slip, with START held alongside RST
        off[2] = 3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        d = 0;
        while (!bus.bs[2] && d < 2000) begin
            @(negedge clk);
            d++;
        end
        check("t6_slip_seen", bus.bs[2], 1);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check_zero("t6_rst");
        rst = 1'b0;
        bus.start = 1'b0;
        d0 = ndrst;
        repeat (4) @(negedge clk);
        check("t6_idle_drst", ndrst - d0, 0);
        check("t6_idle_done", bus.done, 0);
        run(cyc);
        check("t6_done", bus.done, 1);
        check("t6_drst", ndrst - d0, 1);
        check("t6_bs2", nbs[2], 3);
        check("t6_lock", bus.lock, 8'hFF);
        check("t6_err", bus.err, 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/adc_lane_align.md
ADC_LANE_ALIGN -- requirements
Module: adc_lane_align

Interface
REQ-001 SHALL have parameter NLANES, default 8, number of ADC data lanes aligned.
REQ-002 SHALL have parameter WIDTH, default 6, deserialized word width per lane (2..8).
REQ-003 SHALL have parameter PATTERN, default 6'b111000, expected training word (WIDTH bits).
REQ-004 SHALL have parameters SETTLE, default 4, wait cycles after any BS/DINC pulse; NCHECK, default 16, consecutive matches to lock; MAXTAP, default 63, last delay tap tried.
REQ-005 SHALL have port CLK  input  1  fabric clock (ISERDES CLKDIV domain); the only clock.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port START  input  1  one-cycle request to (re)run alignment.
REQ-008 SHALL have port DATA  input  NLANES*WIDTH  deserialized words; lane i = DATA[i*WIDTH +: WIDTH].
REQ-009 SHALL have port BUSY  input  NLANES  IODELAY calibration busy flags.
REQ-010 SHALL have ports BS, DINC  output  NLANES  per-lane one-cycle bitslip / delay-increment pulses.
REQ-011 SHALL have ports DRST, DCAL, SRST  output  1  one-cycle IODELAY reset, IODELAY calibrate, ISERDES reset pulses, common to all lanes.
REQ-012 SHALL have ports LOCK, ERR  output  NLANES  per-lane aligned / failed flags; DONE  output  1  sequence complete.

Function
REQ-013 SHALL implement states IDLE, DRESET, CAL, WAITCAL, CHECK, SLIP, INCDLY, SETTLE, NEXT, DONE.
REQ-014 SHALL, on START in IDLE or DONE, clear LOCK, ERR, DONE, set lane index to 0 and enter DRESET.
REQ-015 SHALL ignore START in all other states.
REQ-016 SHALL in DRESET assert DRST and SRST for exactly one cycle, then enter CAL.
REQ-017 SHALL in CAL assert DCAL for one cycle, then enter WAITCAL.
REQ-018 SHALL remain in WAITCAL at least 2 cycles and until BUSY is all zero, then enter CHECK with slip and tap counters zero.
REQ-019 SHALL in CHECK count consecutive cycles where the current lane word equals PATTERN; a mismatch resets the count.
REQ-020 SHALL on NCHECK consecutive matches set LOCK[lane] and enter NEXT.
REQ-021 SHALL on mismatch with slip count < WIDTH-1 enter SLIP: BS[lane] high one cycle, slip count +1, then SETTLE.
REQ-022 SHALL on mismatch with slip count = WIDTH-1 and tap < MAXTAP enter INCDLY: DINC[lane] high one cycle, tap +1, slip count 0, then SETTLE.
REQ-023 SHALL on mismatch with slip count = WIDTH-1 and tap = MAXTAP set ERR[lane] and enter NEXT.
REQ-024 SHALL in SETTLE wait exactly SETTLE cycles ignoring DATA, then return to CHECK with match count 0.
REQ-025 SHALL in NEXT advance lane index; after lane NLANES-1 enter DONE, else CHECK with counters zero.
REQ-026 SHALL in DONE hold DONE=1 and LOCK/ERR stable until RST or START.
REQ-027 SHALL assert at most one BS/DINC bit at a time, only for the current lane; pulses never exceed one cycle.

Reset
REQ-028 SHALL on RST enter IDLE and drive all outputs 0 on the next edge, aborting any sequence; RST overrides a simultaneous START.

Configuration
REQ-029 SHALL, when ADC_ALIGN_TAPOUT_EN is defined, add output TAP (NLANES*8) holding the final tap count of each lane, zero on RST/START; when undefined, TAP and its storage SHALL not exist and behaviour is otherwise identical.

Structure
REQ-030 SHALL place the state enumeration and tap counter width (8) in shared package adc_pkg.
REQ-031 SHALL contain one sub-module, adc_match_cnt, the consecutive-match counter with clear and NCHECK terminal flag.

Verification
REQ-032 SHALL test all lanes presenting 6'b111000 from START -> no BS/DINC, LOCK=8'hFF, ERR=0, DONE after ~8*16 CHECK cycles.
REQ-033 SHALL test lane 3 rotated by 2 bits, model rotates on BS -> exactly 2 BS[3] pulses, 0 DINC, LOCK[3]=1.
REQ-034 SHALL test lane 5 valid only at tap 2 -> DINC[5] pulsed twice, 5 BS[5] between each, LOCK[5]=1, TAP[5]=2 with macro.
REQ-035 SHALL test lane 0 constant 6'h00 -> 63 DINC pulses, ERR[0]=1, LOCK[0]=0, remaining lanes still locked, DONE=1.
REQ-036 SHALL test BUSY held high 20 cycles after DCAL -> CHECK entered only after BUSY falls.
REQ-037 SHALL test RST asserted in SLIP of lane 2, then START -> outputs 0 next cycle, fresh DRST pulse, full realignment.
